endstop_event_capture: RTL
==========================

Name: endstop_event_capture

Overview:
- Sits directly downstream of the per-axis endstop/debounce stage.
- Timestamps every debounced endstop transition and every rising edge of the axis abort line, and queues the records in a small FIFO.
- Host/bus logic drains the FIFO over a valid/ready interface, so trigger time and debounce cycle count can be read after a homing or abort event.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- TS_WIDTH, 32, width of the free-running timestamp counter.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous reset, active-low
- signal  input  1  debounced endstop level
- signal_changed  input  1  one-cycle pulse when signal changes
- cycles  input  8  debounce cycle count accompanying signal_changed
- abort_in  input  1  axis abort line, level
- enable  input  1  capture enable; when low, no new events are pushed
- clear  input  1  synchronous flush
- rd_valid  output  1  FIFO not empty
- rd_ready  input  1  consumer accepts head entry
- rd_data  output  TS_WIDTH+12  head entry, show-ahead
- count  output  $clog2(DEPTH)+1  entries held
- overflow  output  1  sticky; set when an event was dropped
- dropped  output  8  dropped-event counter, saturates at 255
- timestamp  output  TS_WIDTH  current free-running counter

Behaviour:
- Reset (reset low, asynchronous):
  - timestamp, count, dropped and overflow = 0; rd_valid = 0.
  - rd_data = 0; abort_prev = 0; FIFO pointers = 0.
- Timestamp:
  - Increments by 1 every clk cycle.
  - Wraps modulo 2^TS_WIDTH.
  - Unaffected by clear and enable.
- Abort edge detect:
  - abort_prev is registered each cycle.
  - abort_rise = abort_in & ~abort_prev.
- Event on cycle N: ev = enable & (signal_changed | abort_rise).
- Entry layout, MSB to LSB:
  - src_abort[1] = abort_rise
  - src_sig[1] = signal_changed
  - level[1] = signal
  - abort_lvl[1] = abort_in
  - cycles[8]
  - ts[TS_WIDTH] = timestamp value in cycle N
- Coincident sources: signal_changed and abort_rise in the same cycle produce one entry with both src bits set.
- Latency: an event in cycle N makes the entry visible on rd_data/rd_valid in cycle N+1 (if the FIFO was empty). count updates in cycle N+1.
- Read handshake:
  - A pop occurs when rd_valid & rd_ready at a clock edge.
  - rd_data holds steady while rd_valid & ~rd_ready.
  - rd_ready while empty has no effect.
- Full:
  - An event when count == DEPTH with no pop in the same cycle is dropped.
  - overflow <= 1; dropped increments, saturating at 255.
  - FIFO contents are unchanged.
- Full with simultaneous pop: the push is accepted; count stays DEPTH.
- Empty with simultaneous push and rd_ready: no pop (rd_valid was 0); count becomes 1.
- Clear:
  - Next cycle: count = 0, rd_valid = 0, overflow = 0, dropped = 0.
  - Clear overrides any push or pop in the same cycle; the event in that cycle is lost and not counted as dropped.
  - abort_prev still updates during clear.
- Pointer rules:
  - Read and write pointers are $clog2(DEPTH) bits and wrap naturally.
  - count is tracked separately, so full/empty are unambiguous.
- enable low: events are ignored (not counted as dropped); reads continue normally.
- Reset mid-operation: all state returns to reset values immediately; queued entries are lost.

Decomposition:
- Shared package endstop_pkg holds:
  - field offset/width localparams ENTRY_W, ENTRY_TS_LSB, ENTRY_CYC_LSB, ENTRY_ABORT_LVL_BIT, ENTRY_LEVEL_BIT, ENTRY_SRC_SIG_BIT, ENTRY_SRC_ABORT_BIT;
  - DROPPED_MAX = 255.
- One natural sub-module, event_fifo: parameterised synchronous show-ahead FIFO.
  - Ports: push, pop, flush, data in/out, count, full, empty.
  - Same async active-low reset.
- Event formation, timestamp, edge detect and overflow accounting stay in the top.

Test Plan:
- Reset low for 3 cycles, then release:
  - During reset, all outputs are 0.
  - timestamp counts 0,1,2… from the first edge after release.
- enable=1; pulse signal_changed at timestamp=100 with signal=1, cycles=8'h23, abort_in=0:
  - Next cycle rd_valid=1.
  - rd_data = src_abort 0, src_sig 1, level 1, abort_lvl 0, cycles 0x23, ts 100; count=1.
  - With rd_ready=1 for one cycle, count becomes 0.
- abort_in rises in the same cycle as signal_changed (signal=0):
  - Exactly one entry, src bits = 2'b11, abort_lvl=1.
  - Holding abort_in high produces no further entries.
- Push 8 events with rd_ready=0, then push 3 more:
  - count=8, overflow=1, dropped=3.
  - Draining yields the first 8 timestamps in order.
  - A push at count 8 with a simultaneous pop is accepted.
- Assert clear together with an event and a pop while count=5, overflow=1:
  - Next cycle count=0, rd_valid=0, overflow=0, dropped=0.
  - timestamp continues incrementing without a break.
- Preload timestamp near wrap (TS_WIDTH=8 build), event at ts=255 then at ts=0 → entries carry 255 then 0.
- With enable=0, pulse signal_changed → no entry, dropped unchanged.

Source files
------------

// File: rtl/endstop_event_capture_pkg.sv
// Shared entry layout and limits for the endstop event capture block.
// Header field offsets are relative to the top of the timestamp field.
package endstop_pkg;

    localparam int TS_WIDTH_DEF        = 32;
    localparam int ENTRY_HDR_W         = 12;
    localparam int ENTRY_W             = TS_WIDTH_DEF + ENTRY_HDR_W;

    localparam int ENTRY_TS_LSB        = 0;
    localparam int ENTRY_CYC_LSB       = 0;
    localparam int ENTRY_ABORT_LVL_BIT = 8;
    localparam int ENTRY_LEVEL_BIT     = 9;
    localparam int ENTRY_SRC_SIG_BIT   = 10;
    localparam int ENTRY_SRC_ABORT_BIT = 11;

    localparam logic [7:0] DROPPED_MAX = 8'd255;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == DROPPED_MAX) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/endstop_event_capture_fifo.sv
// Synchronous show-ahead FIFO; count is tracked separately from the pointers
// so full and empty are unambiguous. Flush overrides push and pop.
module event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 44
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_s;
    logic             empty_s;
    logic             do_pop_s;
    logic             do_push_s;

    assign full_s    = (count_q == CNT_W'(DEPTH));
    assign empty_s   = (count_q == {CNT_W{1'b0}});
    assign do_pop_s  = pop_i & ~empty_s;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push_s = push_i & (~full_s | do_pop_s);

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CNT_W'(1'b1);
                2'b01:   count_d = count_q - CNT_W'(1'b1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = full_s;
    assign empty_o = empty_s;

endmodule

// File: rtl/endstop_event_capture.sv
// Timestamps debounced endstop transitions and abort rising edges, queueing
// the records in a show-ahead FIFO drained over a valid/ready interface.
module endstop_event_capture
    import endstop_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int TS_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   signal,
    input  logic                   signal_changed,
    input  logic [7:0]             cycles,
    input  logic                   abort_in,
    input  logic                   enable,
    input  logic                   clear,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [TS_WIDTH+11:0]   rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [7:0]             dropped,
    output logic [TS_WIDTH-1:0]    timestamp
);

    localparam int EW = ENTRY_W - TS_WIDTH_DEF + TS_WIDTH;

    logic [TS_WIDTH-1:0]    ts_q, ts_d;
    logic                   abort_prev_q;
    logic                   overflow_q, overflow_d;
    logic [7:0]             dropped_q, dropped_d;
    logic                   abort_rise_s;
    logic                   ev_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   drop_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic [$clog2(DEPTH):0] fifo_count_s;
    logic [EW-1:0]          entry_s;
    logic [EW-1:0]          fifo_rdata_s;

    assign abort_rise_s = abort_in & ~abort_prev_q;
    assign ev_s         = enable & (signal_changed | abort_rise_s);
    assign pop_s        = rd_ready & ~fifo_empty_s;
    assign push_s       = ev_s & (~fifo_full_s | pop_s);
    assign drop_s       = ev_s & fifo_full_s & ~pop_s;

    // Pack the record for the current cycle.
    always_comb begin
        entry_s = {EW{1'b0}};
        entry_s[ENTRY_TS_LSB +: TS_WIDTH]              = ts_q;
        entry_s[TS_WIDTH + ENTRY_CYC_LSB +: 8]         = cycles;
        entry_s[TS_WIDTH + ENTRY_ABORT_LVL_BIT]        = abort_in;
        entry_s[TS_WIDTH + ENTRY_LEVEL_BIT]            = signal;
        entry_s[TS_WIDTH + ENTRY_SRC_SIG_BIT]          = signal_changed;
        entry_s[TS_WIDTH + ENTRY_SRC_ABORT_BIT]        = abort_rise_s;
    end

    // Timestamp and drop accounting; clear only touches the accounting.
    always_comb begin
        ts_d       = ts_q + TS_WIDTH'(1'b1);
        overflow_d = overflow_q;
        dropped_d  = dropped_q;
        if (clear) begin
            overflow_d = 1'b0;
            dropped_d  = 8'd0;
        end else if (drop_s) begin
            overflow_d = 1'b1;
            dropped_d  = sat_inc8(dropped_q);
        end else begin
            overflow_d = overflow_q;
            dropped_d  = dropped_q;
        end
    end

    // Free-running state, abort edge history and drop accounting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_q         <= {TS_WIDTH{1'b0}};
            abort_prev_q <= 1'b0;
            overflow_q   <= 1'b0;
            dropped_q    <= 8'd0;
        end else begin
            ts_q         <= ts_d;
            abort_prev_q <= abort_in;
            overflow_q   <= overflow_d;
            dropped_q    <= dropped_d;
        end
    end

    event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .flush_i (clear),
        .wdata_i (entry_s),
        .rdata_o (fifo_rdata_s),
        .count_o (fifo_count_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    assign rd_valid  = ~fifo_empty_s;
    assign rd_data   = fifo_rdata_s;
    assign count     = fifo_count_s;
    assign overflow  = overflow_q;
    assign dropped   = dropped_q;
    assign timestamp = ts_q;

endmodule
